axi4_lite_read_responder: RTL and testbench

Slave-side responder for the AXI4-Lite read path: accepts read addresses on the AR channel, fetches a word from local storage, and returns it on the R channel with an RRESP code. It sits on the slave end of the bus interface, opposite the master's read initiator. Its storage is shared with the write path through a simple synchronous write port. Every completed read increments a saturating counter.

---
 rtl/axi4_lite_read_responder.sv | 120 ++++++++++++
 tb/tb_axi4_lite_read_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_responder.sv
// AXI4-Lite read-path slave: AR accept -> storage fetch -> R response, with a saturating read counter.
// Optional build macro AXI_RD_ERR_EN: out-of-range reads return SLVERR with zero data instead of wrapping.
module axi4_lite_read_responder #(
    parameter int Addr_Width = 32,
    parameter int Data_Width = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [Addr_Width-1:0]        ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [Data_Width-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [Data_Width-1:0]        mem_wdata,
    output logic [15:0]                  rd_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    state_t                  state;
    logic [Addr_Width-1:0]   addr_q;
    logic [IDX_W-1:0]        idx;
    logic [Data_Width-1:0]   mem [MEM_DEPTH];

    // Byte offset bits are dropped; upper bits beyond the index wrap unless range-checked.
    assign idx = addr_q[IDX_W+1:2];

`ifdef AXI_RD_ERR_EN
    logic [Addr_Width-1:0] word_addr;
    logic                  out_of_range;

    assign word_addr    = addr_q >> 2;
    assign out_of_range = (word_addr >= Addr_Width'(MEM_DEPTH));
`endif

    // ARPROT carries no meaning for this responder; only part of addr_q feeds the index.
    logic unused_sink;
    assign unused_sink = ^{ARPROT, addr_q};

    // NOTE: storage has no reset term, so it maps onto RAM; contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: non-blocking assignments make the FETCH read see the pre-write word on a same-edge write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            rd_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARVALID && ARREADY) begin
                        addr_q  <= ARADDR;
                        ARREADY <= 1'b0;
                        state   <= FETCH;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end

                FETCH: begin
`ifdef AXI_RD_ERR_EN
                    if (out_of_range) begin
                        RDATA <= '0;
                        RRESP <= RESP_SLVERR;
                    end else begin
                        RDATA <= mem[idx];
                        RRESP <= RESP_OKAY;
                    end
`else
                    RDATA <= mem[idx];
                    RRESP <= RESP_OKAY;
`endif
                    RVALID <= 1'b1;
                    state  <= RESP;
                end

                RESP: begin
                    // RDATA/RRESP are left untouched here, so they hold through any stall.
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        if (rd_count != 16'hFFFF) begin
                            rd_count <= rd_count + 16'd1;
                        end
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ARREADY <= 1'b0;
                    RVALID  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_responder.sv
// Directed self-checking bench for axi4_lite_read_responder (default depth 1024, 32-bit words).
module tb_axi4_lite_read_responder;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] rd_count;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_count = 16'd0;

    axi4_lite_read_responder #(
        .Addr_Width(32),
        .Data_Width(32),
        .MEM_DEPTH (1024)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .rd_count (rd_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic mem_write(input logic [9:0] a, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = a;
        mem_wdata = d;
        tick();
        mem_we = 1'b0;
    endtask

    // One full read. stall = cycles RREADY is held low in RESP; wr_fetch plants a
    // storage write on the same edge that ends FETCH.
    task automatic do_read(input string name, input logic [31:0] addr, input int stall,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input bit wr_fetch, input logic [9:0] wr_idx,
                           input logic [31:0] wr_data);
        check({name, "_arready_idle"}, 32'(ARREADY), 32'd1);
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = (stall == 0);
        tick();
        ARVALID = 1'b0;
        check({name, "_arready_fetch"}, 32'(ARREADY), 32'd0);
        check({name, "_rvalid_fetch"}, 32'(RVALID), 32'd0);
        if (wr_fetch) begin
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            mem_wdata = wr_data;
        end
        tick();
        mem_we = 1'b0;
        check({name, "_rvalid"}, 32'(RVALID), 32'd1);
        check({name, "_rdata"}, RDATA, exp_data);
        check({name, "_rresp"}, 32'(RRESP), 32'(exp_resp));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, "_stall_rvalid"}, 32'(RVALID), 32'd1);
            check({name, "_stall_rdata"}, RDATA, exp_data);
            check({name, "_stall_rresp"}, 32'(RRESP), 32'(exp_resp));
            check({name, "_stall_arready"}, 32'(ARREADY), 32'd0);
        end
        RREADY = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        check({name, "_rvalid_done"}, 32'(RVALID), 32'd0);
        check({name, "_arready_done"}, 32'(ARREADY), 32'd1);
        check({name, "_count"}, 32'(rd_count), 32'(exp_count));
    endtask

    logic [31:0] exp_oor_data;
    logic [1:0]  exp_oor_resp;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];

    initial begin
        ARESET    = 1'b1;
        ARADDR    = '0;
        ARPROT    = 3'b010;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        tick();
        tick();
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_rresp", 32'(RRESP), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);

        // Storage loads happen while reset is held; reset must not disturb them.
        mem_write(10'h091, 32'h2468_1357);
        mem_write(10'h000, 32'hDEAD_BEEF);
        mem_write(10'h005, 32'h5555_5555);

        ARESET = 1'b0;
        check("release_arready_before", 32'(ARREADY), 32'd0);
        tick();
        check("release_arready_after", 32'(ARREADY), 32'd1);

        do_read("basic", 32'h0000_0246, 0, 32'h2468_1357, 2'b00, 1'b0, '0, '0);
        do_read("stall", 32'h0000_0246, 4, 32'h2468_1357, 2'b00, 1'b0, '0, '0);

`ifdef AXI_RD_ERR_EN
        exp_oor_data = 32'h0000_0000;
        exp_oor_resp = 2'b10;
`else
        exp_oor_data = 32'hDEAD_BEEF;
        exp_oor_resp = 2'b00;
`endif
        do_read("oor", 32'h0000_1000, 0, exp_oor_data, exp_oor_resp, 1'b0, '0, '0);

        do_read("raw_old", 32'h0000_0014, 0, 32'h5555_5555, 2'b00, 1'b1, 10'h005, 32'hAAAA_0000);
        do_read("raw_new", 32'h0000_0017, 0, 32'hAAAA_0000, 2'b00, 1'b0, '0, '0);

        // Reset while parked in RESP.
        ARADDR  = 32'h0000_0246;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        tick();
        ARVALID = 1'b0;
        tick();
        check("midrst_rvalid_before", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        tick();
        check("midrst_rvalid", 32'(RVALID), 32'd0);
        check("midrst_arready", 32'(ARREADY), 32'd0);
        check("midrst_count", 32'(rd_count), 32'd0);
        check("midrst_rdata", RDATA, 32'd0);
        exp_count = 16'd0;
        ARESET = 1'b0;
        tick();
        check("midrst_arready_release", 32'(ARREADY), 32'd1);
        do_read("after_rst", 32'h0000_0246, 0, 32'h2468_1357, 2'b00, 1'b0, '0, '0);

        // Back-to-back reads with ARVALID and RREADY held high.
        b2b_addr[0] = 32'h0000_0246; b2b_data[0] = 32'h2468_1357;
        b2b_addr[1] = 32'h0000_0014; b2b_data[1] = 32'hAAAA_0000;
        b2b_addr[2] = 32'h0000_0000; b2b_data[2] = 32'hDEAD_BEEF;
        ARADDR  = b2b_addr[0];
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            case (k % 3)
                0: begin
                    check("b2b_arready_p0", 32'(ARREADY), 32'd0);
                    check("b2b_rvalid_p0", 32'(RVALID), 32'd0);
                    if (k / 3 < 2) ARADDR = b2b_addr[k / 3 + 1];
                end
                1: begin
                    check("b2b_arready_p1", 32'(ARREADY), 32'd0);
                    check("b2b_rvalid_p1", 32'(RVALID), 32'd1);
                    check("b2b_rdata", RDATA, b2b_data[k / 3]);
                end
                default: begin
                    exp_count = exp_count + 16'd1;
                    check("b2b_arready_p2", 32'(ARREADY), 32'd1);
                    check("b2b_rvalid_p2", 32'(RVALID), 32'd0);
                    check("b2b_count", 32'(rd_count), 32'(exp_count));
                    if (k == 8) ARVALID = 1'b0;
                end
            endcase
        end
        tick();
        check("b2b_idle_arready", 32'(ARREADY), 32'd1);
        check("b2b_idle_rvalid", 32'(RVALID), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
